// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the parameterised VGA controller.
//   * default 640x480@60 timing constants (pixels / lines)
//   * region_t: per-axis position inside a line or frame
//   * pixel_t:  {r,g,b} pixel at the default channel width
//   * bar_color(): colour table for the eight-bar test pattern, used
//     when the design is built with VGA_TEST_PATTERN_EN
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_COLOR_W  = 4;
    localparam int NUM_BARS     = 8;

    // Order matches the scan order along each axis.
    typedef enum logic [1:0] {
        RGN_ACTIVE = 2'd0,
        RGN_FP     = 2'd1,
        RGN_SYNC   = 2'd2,
        RGN_BP     = 2'd3
    } region_t;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } pixel_t;

    // One bit per channel {r,g,b}; a set bit drives that channel all-ones.
    typedef logic [2:0] bar_mask_t;

    function automatic bar_mask_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111; // white
            3'd1:    return 3'b110; // yellow
            3'd2:    return 3'b011; // cyan
            3'd3:    return 3'b010; // green
            3'd4:    return 3'b101; // magenta
            3'd5:    return 3'b100; // red
            3'd6:    return 3'b001; // blue
            default: return 3'b000; // black
        endcase
    endfunction

endpackage

// File: rtl/vga_ctrl_param_sync_counter.sv
// vga_sync_counter -- horizontal/vertical scan counters and region decode.
//   vga_clk, clrn      : pixel clock, async active-low reset
//   h_cnt, v_cnt       : current pixel column / line (stage 0)
//   h_region, v_region : active / front porch / sync / back porch per axis
// The frame wraps from the last pixel of the last line straight to (0,0).
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          vga_clk,
    input  logic          clrn,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output region_t       h_region,
    output region_t       v_region
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_FP_BEG = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SY_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_BP_BEG = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FP_BEG = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SY_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_BP_BEG = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_comb begin
        h_region = RGN_BP;
        if (h_cnt < H_FP_BEG)      h_region = RGN_ACTIVE;
        else if (h_cnt < H_SY_BEG) h_region = RGN_FP;
        else if (h_cnt < H_BP_BEG) h_region = RGN_SYNC;

        v_region = RGN_BP;
        if (v_cnt < V_FP_BEG)      v_region = RGN_ACTIVE;
        else if (v_cnt < V_SY_BEG) v_region = RGN_FP;
        else if (v_cnt < V_BP_BEG) v_region = RGN_SYNC;
    end

endmodule

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param -- parameterised VGA timing controller with pixel fetch.
//   vga_clk, clrn        : pixel clock, async active-low reset
//   test_en              : colour-bar select (only with VGA_TEST_PATTERN_EN)
//   d_in                 : {r,g,b} pixel from the source, RD_LAT after rdn
//   row_addr, col_addr   : requested pixel, registered from the counters
//   rdn                  : active-low read strobe, low for active requests
//   r, g, b              : colour, blanked outside the active area
//   hs, vs               : syncs at HS_POL / VS_POL
//   frame_start          : one-cycle pulse aligned with pixel (0,0) on r/g/b
// Build option: define VGA_TEST_PATTERN_EN to add test_en and the
// eight-bar generator; otherwise pixels always come from d_in.
// Pipeline: counters (stage 0, cycle n) -> address/rdn (n+1) ->
// d_in (n+1+RD_LAT) -> r/g/b (n+PD), PD = RD_LAT+2. Syncs, active flag
// and frame_start travel alongside so everything leaves aligned.
module vga_ctrl_param
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1
) (
    input  logic                 vga_clk,
    input  logic                 clrn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_en,
`endif
    input  logic [3*COLOR_W-1:0] d_in,
    output logic [ADDR_W-1:0]    row_addr,
    output logic [ADDR_W-1:0]    col_addr,
    output logic                 rdn,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 hs,
    output logic                 vs,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PD      = RD_LAT + 2;
    // One spare count of headroom so every region boundary fits the counter.
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("vga_ctrl_param: RD_LAT must be within 1..4");
    end

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // ---------------- stage 0: counters and decode ----------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    region_t       h_region, v_region;
    logic          active, first_px, read_req;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_sync (
        .vga_clk  (vga_clk),
        .clrn     (clrn),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .h_region (h_region),
        .v_region (v_region)
    );

    assign active   = (h_region == RGN_ACTIVE) && (v_region == RGN_ACTIVE);
    assign first_px = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    // Bar position tracked incrementally alongside h_cnt so no divider
    // by H_ACTIVE/8 is needed. bar_idx saturates once past the last bar.
    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);

    logic [BPW-1:0] bar_pos;
    logic [2:0]     bar_idx;
    logic [PD-1:1]  tp_pipe;
    logic [PD-1:1][2:0] mask_pipe;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (h_cnt == H_LAST) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_pos == BAR_LAST) begin
            bar_pos <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pos <= bar_pos + BPW'(1);
        end
    end

    // Test mode and bar colour only need to reach the r/g/b register,
    // which loads one stage before the outputs.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            tp_pipe   <= '0;
            mask_pipe <= '0;
        end else begin
            tp_pipe   <= {tp_pipe[PD-2:1], test_en};
            mask_pipe <= {mask_pipe[PD-2:1], bar_color(bar_idx)};
        end
    end

    assign read_req = active & ~test_en;
`else
    assign read_req = active;
`endif

    // ---------------- stage 1: address and read strobe ----------------
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            col_addr <= '0;
            row_addr <= '0;
            rdn      <= 1'b1;
        end else begin
            col_addr <= active ? ADDR_W'(h_cnt) : '0;
            row_addr <= active ? ADDR_W'(v_cnt) : '0;
            rdn      <= ~read_req;
        end
    end

    // ---------------- alignment pipes ----------------
    // hs/vs are carried as "in sync region" so an all-zero reset state
    // maps to the inactive level for either polarity.
    logic [PD:1] vld_pipe, hs_pipe, vs_pipe, fs_pipe;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            vld_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            fs_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PD-1:1], active};
            hs_pipe  <= {hs_pipe[PD-1:1],  h_region == RGN_SYNC};
            vs_pipe  <= {vs_pipe[PD-1:1],  v_region == RGN_SYNC};
            fs_pipe  <= {fs_pipe[PD-1:1],  first_px};
        end
    end

    // ---------------- stage PD: pixel register ----------------
    rgb_t px_src, px_q;

    always_comb begin
        px_src = rgb_t'(d_in);
`ifdef VGA_TEST_PATTERN_EN
        if (tp_pipe[PD-1])
            px_src = {{COLOR_W{mask_pipe[PD-1][2]}},
                      {COLOR_W{mask_pipe[PD-1][1]}},
                      {COLOR_W{mask_pipe[PD-1][0]}}};
`endif
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) px_q <= '0;
        else       px_q <= px_src;
    end

    // Blank with the aligned active flag; data captured outside the
    // active area (or before the pipe fills) never reaches the pins.
    assign r = vld_pipe[PD] ? px_q.r : '0;
    assign g = vld_pipe[PD] ? px_q.g : '0;
    assign b = vld_pipe[PD] ? px_q.b : '0;

    assign hs          = (HS_POL != 0) ? hs_pipe[PD] : ~hs_pipe[PD];
    assign vs          = (VS_POL != 0) ? vs_pipe[PD] : ~vs_pipe[PD];
    assign frame_start = fs_pipe[PD];

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Directed bench on a reduced raster (24x8 total, 16x4 active) so whole
// frames fit in a short run. u_dut: RD_LAT=3, active-low syncs, d_in from
// a latency model returning {col,row,~col} LSBs. u_pos: RD_LAT=1,
// active-high syncs, d_in tied to all-ones.
module tb_vga_ctrl_param;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3, HT = 24;
    localparam int VA = 4,  VF = 1, VSY = 2, VB = 1, VT = 8;
    localparam int FRAME = HT * VT;
    localparam int LAT1 = 3, PD1 = LAT1 + 2, PD2 = 3;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [11:0] d_in;
    logic [9:0]  row_addr, col_addr, row2, col2;
    logic        rdn, rdn2, hs, vs, hs2, vs2, fs, fs2;
    logic [3:0]  r, g, b, r2, g2, b2;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_en;
`endif

    int nvec = 0, nerr = 0;
    int cnt_rdn = 0, cnt_hs = 0, cnt_vs = 0, cnt_act2 = 0;
    bit tp_mode = 1'b0;
    logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                3'b101, 3'b100, 3'b001, 3'b000};

    always #5 vga_clk = ~vga_clk;

    vga_ctrl_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .COLOR_W(4), .ADDR_W(10), .RD_LAT(LAT1)
    ) u_dut (
        .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .d_in(d_in), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .frame_start(fs)
    );

    vga_ctrl_param #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .COLOR_W(4), .ADDR_W(10), .RD_LAT(1)
    ) u_pos (
        .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .d_in(12'hFFF), .row_addr(row2), .col_addr(col2), .rdn(rdn2),
        .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .frame_start(fs2)
    );

    // Pixel source with LAT1 cycles of read latency.
    logic [11:0] dq [LAT1];
    always_ff @(posedge vga_clk) begin
        dq[0] <= rdn ? 12'hABC : {col_addr[3:0], row_addr[3:0], ~col_addr[3:0]};
        for (int i = 1; i < LAT1; i++) dq[i] <= dq[i-1];
    end
    assign d_in = dq[LAT1-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic decode(input int pix, output int h, output int v,
                          output bit act, output bit ihs, output bit ivs);
        int p;
        p   = pix % FRAME;
        h   = p % HT;
        v   = p / HT;
        act = (h < HA) && (v < VA);
        ihs = (h >= HA + HF) && (h < HA + HF + HSY);
        ivs = (v >= VA + VF) && (v < VA + VF + VSY);
    endtask

    task automatic check_reset();
        chk("rst_rdn", rdn, 1);        chk("rst_col", col_addr, 0);
        chk("rst_row", row_addr, 0);   chk("rst_rgb", {r, g, b}, 0);
        chk("rst_hs", hs, 1);          chk("rst_vs", vs, 1);
        chk("rst_fs", fs, 0);          chk("rst_rdn2", rdn2, 1);
        chk("rst_rgb2", {r2, g2, b2}, 0);
        chk("rst_hs2", hs2, 0);        chk("rst_vs2", vs2, 0);
        chk("rst_fs2", fs2, 0);
    endtask

    // k = number of rising edges since reset release.
    task automatic check_cycle(input int k);
        int h, v;
        bit act, ihs, ivs;
        logic [3:0]  h4, v4;
        logic [2:0]  m;
        logic [11:0] e;
        // request side: pixel k-1
        decode(k - 1, h, v, act, ihs, ivs);
        chk("col_addr", col_addr, act ? h : 0);
        chk("row_addr", row_addr, act ? v : 0);
        chk("rdn", rdn, (act && !tp_mode) ? 0 : 1);
        chk("col2", col2, act ? h : 0);
        chk("rdn2", rdn2, act ? 0 : 1);
        if (k <= FRAME && rdn === 1'b0) cnt_rdn++;
        // u_dut outputs: pixel k-PD1
        if (k < PD1) begin
            chk("rgb_fill", {r, g, b}, 0); chk("hs_fill", hs, 1);
            chk("vs_fill", vs, 1);         chk("fs_fill", fs, 0);
        end else begin
            decode(k - PD1, h, v, act, ihs, ivs);
            h4 = h[3:0];
            v4 = v[3:0];
            m  = bar_tab[(h / 2) % 8];
            if (!act)        e = 12'h000;
            else if (tp_mode) e = {{4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
            else             e = {h4, v4, ~h4};
            chk("rgb", {r, g, b}, e);
            chk("hs", hs, ihs ? 0 : 1);
            chk("vs", vs, ivs ? 0 : 1);
            chk("frame_start", fs, ((k - PD1) % FRAME == 0) ? 1 : 0);
            if (k < PD1 + FRAME) begin
                if (hs === 1'b0) cnt_hs++;
                if (vs === 1'b0) cnt_vs++;
            end
        end
        // u_pos outputs: pixel k-PD2
        if (k < PD2) begin
            chk("rgb2_fill", {r2, g2, b2}, 0); chk("hs2_fill", hs2, 0);
            chk("vs2_fill", vs2, 0);           chk("fs2_fill", fs2, 0);
        end else begin
            decode(k - PD2, h, v, act, ihs, ivs);
            chk("rgb2", {r2, g2, b2}, act ? 12'hFFF : 12'h000);
            chk("hs2", hs2, ihs ? 1 : 0);
            chk("vs2", vs2, ivs ? 1 : 0);
            chk("fs2", fs2, ((k - PD2) % FRAME == 0) ? 1 : 0);
            if (k < PD2 + FRAME && r2 === 4'hF) cnt_act2++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge vga_clk);
            check_cycle(k);
        end
    endtask

    initial begin
        clrn = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        test_en = 1'b0;
`endif
        repeat (10) @(negedge vga_clk);
        check_reset();
        clrn = 1'b1;

        // Two full frames, then stop at line 2 column 5 of the third.
        run(2 * FRAME + 2 * HT + 5);
        chk("rdn_low_per_frame", cnt_rdn, HA * VA);
        chk("hs_low_per_frame", cnt_hs, HSY * VT);
        chk("vs_low_per_frame", cnt_vs, VSY * HT);
        chk("active_px_per_frame2", cnt_act2, HA * VA);

        // Mid-frame reset: must hit outputs without waiting for a clock.
        clrn = 1'b0;
        #1;
        check_reset();
        repeat (3) begin
            @(negedge vga_clk);
            check_reset();
        end
        clrn = 1'b1;
        run(PD1 + FRAME + 5);

`ifdef VGA_TEST_PATTERN_EN
        clrn    = 1'b0;
        test_en = 1'b1;
        tp_mode = 1'b1;
        @(negedge vga_clk);
        check_reset();
        clrn = 1'b1;
        run(PD1 + 2 * HT + 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
